// File: rtl/sec_loc_pkg.sv
// Shared types and H-matrix column lookup for the 28b SEC location decoder.
package sec_loc_pkg;
  localparam int D_BITS   = 28;
  localparam int C_BITS   = 8;
  localparam int W_BITS   = D_BITS + C_BITS;
  localparam int N_BITS   = D_BITS + 1;
  localparam int IDX_BITS = 6;

  typedef enum logic [1:0] {IDLE, SYND, SEARCH, DONE} state_t;

  // Data columns carry a 3'b111 tag so they never alias a unit check column.
  function automatic logic [C_BITS-1:0] col(input logic [IDX_BITS-1:0] idx);
    logic [C_BITS-1:0] c;
    if (idx < IDX_BITS'(D_BITS)) c = {3'b111, idx[4:0]};
    else                         c = C_BITS'(1) << (idx - IDX_BITS'(D_BITS));
    return c;
  endfunction
endpackage

// File: rtl/sec_loc_syndrome.sv
// Combinational syndrome of a 36b codeword: check bits XOR the H columns of all set data bits.
module sec_loc_syndrome
  import sec_loc_pkg::*;
(
  input  logic [W_BITS-1:0] w,
  output logic [C_BITS-1:0] s
);
  always_comb begin
    s = w[W_BITS-1:D_BITS];
    for (int j = 0; j < D_BITS; j++) begin
      if (w[j]) s = s ^ col(IDX_BITS'(j));
    end
  end
endmodule

// File: rtl/sec_decoder_location_28b.sv
// SEC decoder: syndrome then location search (one column per cycle, or all at once under SEC_LOC_PARALLEL_EN).
// Latency 3..39 cycles from a W change to found (3 fixed when parallel); a W change restarts the decode.
module sec_decoder_location_28b
  import sec_loc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W_BITS-1:0]   W,
  output logic [N_BITS-1:0]   N,
  output logic                found
);
  state_t                state, state_nxt;
  logic [W_BITS-1:0]     w_q;
  logic [C_BITS-1:0]     s_q, s_nxt, syn;
  logic [IDX_BITS-1:0]   idx, idx_nxt;
  logic                  first, first_nxt;
  logic                  found_nxt;
  logic [N_BITS-1:0]     n_nxt;
  logic [D_BITS-1:0]     seq_flip;

  sec_loc_syndrome u_syndrome (
    .w (w_q),
    .s (syn)
  );

  assign seq_flip = (idx < IDX_BITS'(D_BITS)) ? (D_BITS'(1) << idx) : '0;

`ifdef SEC_LOC_PARALLEL_EN
  logic              par_hit;
  logic [D_BITS-1:0] par_flip;

  always_comb begin
    par_hit  = 1'b0;
    par_flip = '0;
    for (int i = 0; i < W_BITS; i++) begin
      if (syn == col(IDX_BITS'(i))) begin
        par_hit = 1'b1;
        if (i < D_BITS) par_flip = D_BITS'(1) << i;
      end
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    n_nxt     = N;
    found_nxt = found;
    idx_nxt   = idx;
    s_nxt     = s_q;
    first_nxt = first;
    // Any change of W abandons whatever decode is in flight.
    if (first || (W != w_q)) begin
      found_nxt = 1'b0;
      first_nxt = 1'b0;
      state_nxt = SYND;
    end else begin
      case (state)
        SYND: begin
          s_nxt = syn;
          if (syn == '0) begin
            n_nxt     = {1'b0, w_q[D_BITS-1:0]};
            state_nxt = DONE;
          end else begin
`ifdef SEC_LOC_PARALLEL_EN
            n_nxt     = par_hit ? {1'b0, w_q[D_BITS-1:0] ^ par_flip}
                                : {1'b1, w_q[D_BITS-1:0]};
            state_nxt = DONE;
`else
            idx_nxt   = '0;
            state_nxt = SEARCH;
`endif
          end
        end
        SEARCH: begin
          if (s_q == col(idx)) begin
            n_nxt     = {1'b0, w_q[D_BITS-1:0] ^ seq_flip};
            state_nxt = DONE;
          end else if (idx == IDX_BITS'(W_BITS - 1)) begin
            n_nxt     = {1'b1, w_q[D_BITS-1:0]};
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + IDX_BITS'(1);
          end
        end
        DONE:    found_nxt = 1'b1;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w_q   <= '0;
      s_q   <= '0;
      idx   <= '0;
      first <= 1'b1;
      found <= 1'b0;
      N     <= '0;
    end else begin
      state <= state_nxt;
      w_q   <= W;
      s_q   <= s_nxt;
      idx   <= idx_nxt;
      first <= first_nxt;
      found <= found_nxt;
      N     <= n_nxt;
    end
  end
endmodule

// File: tb/tb_sec_decoder_location_28b.sv
// Scoreboard bench for sec_decoder_location_28b: directed codewords, expected results queued at issue time.
module tb_sec_decoder_location_28b;
  logic        clk;
  logic        rst_n;
  logic [35:0] W;
  logic [28:0] N;
  logic        found;

  int errors = 0;
  int checks = 0;
  logic [28:0] exp_q[$];

  sec_decoder_location_28b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .W     (W),
    .N     (N),
    .found (found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int explat(input int seq_lat);
`ifdef SEC_LOC_PARALLEL_EN
    return 3;
`else
    return seq_lat;
`endif
  endfunction

  function automatic int mid_wait();
`ifdef SEC_LOC_PARALLEL_EN
    return 1;
`else
    return 10;
`endif
  endfunction

  // Monitor: every rising edge of found must match the oldest queued expectation.
  initial begin : monitor
    logic        found_prev;
    logic [28:0] exp;
    found_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (found && !found_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_found: N=%h with no result pending", N);
        end else begin
          exp = exp_q.pop_front();
          if (N !== exp) begin
            errors++;
            $display("FAIL result: N=%h required=%h", N, exp);
          end
        end
      end
      found_prev = found;
    end
  end

  task automatic wait_found(input int lat, input string name);
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!found && cnt < 64);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s timeout: found=0 after %0d cycles, required within %0d", name, cnt, lat);
    end else if (cnt != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, cnt, lat);
    end
  endtask

  task automatic run(input logic [35:0] w, input logic [28:0] exp, input int lat, input string name);
    @(negedge clk);
    W = w;
    exp_q.push_back(exp);
    wait_found(explat(lat), name);
  endtask

  initial begin : stim
    bit ok;
    rst_n = 1'b0;
    W     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (N !== 29'd0) begin errors++; $display("FAIL reset_N: N=%h required=0", N); end
    checks++;
    if (found !== 1'b0) begin errors++; $display("FAIL reset_found: found=%b required=0", found); end

    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(29'd0);
    wait_found(explat(3), "reset_release");

    run(36'h00FFFFFFF, 29'h0FFFFFFF,  3, "clean");
    run(36'h00FFFFFDF, 29'h0FFFFFFF,  9, "data_bit5");
    run(36'h10FFFFFFF, 29'h0FFFFFFF, 36, "check_bit4");
    run(36'h00FFFFFF6, 29'h1FFFFFF6, 39, "double_0_3");
    run(36'h000000001, 29'h0000000,   4, "data_bit0");
    run(36'h008000000, 29'h0000000,  31, "data_bit27");
    run(36'h010000000, 29'h0000000,  32, "check_bit0");
    run(36'h800000000, 29'h0000000,  39, "check_bit7");
    run(36'h010000003, 29'h0000003,   3, "clean_3");
    run(36'h010000001, 29'h0000003,   5, "data_bit1");

    // Same W again: found must stay high with no new result.
    @(negedge clk);
    W  = 36'h010000001;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!found) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL same_w_hold: found dropped, required held at 1"); end

    // Abandon a decode in flight; only the replacement word may produce a result.
    @(negedge clk);
    W = 36'h00FFFFFF6;
    repeat (mid_wait()) @(posedge clk);
    #1;
    checks++;
    if (found !== 1'b0) begin errors++; $display("FAIL mid_search_found: found=%b required=0", found); end
    @(negedge clk);
    W = 36'h00FFFFFDF;
    exp_q.push_back(29'h0FFFFFFF);
    wait_found(explat(9), "restart");

    // Asynchronous reset in the middle of a decode.
    @(negedge clk);
    W = 36'h800000000;
    repeat (mid_wait()) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (N !== 29'd0) begin errors++; $display("FAIL async_reset_N: N=%h required=0", N); end
    checks++;
    if (found !== 1'b0) begin errors++; $display("FAIL async_reset_found: found=%b required=0", found); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(29'd0);
    wait_found(explat(39), "after_reset");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d results never presented, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
